// File: rtl/uart_sector_bridge.sv
// rtl/uart_sector_bridge.sv - UART command transmitter and response receiver feeding a 16-bit sector buffer.
// Optional: define UART_PARITY_EN for 8E1 framing in both directions (default 8N1).
module uart_sector_bridge #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int BUF_WORDS = 32768,
  parameter int CMD_BYTES = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   uart_start,
  input  logic [CMD_BYTES*8-1:0] cmd_buf,
  input  logic                   reset_bytes_transmitted,
  input  logic                   buffer_read,
  input  logic [15:0]            read_addr,
  output logic [15:0]            word_in,
  output logic [15:0]            bytes_in,
  output logic                   uart_tx,
  input  logic                   uart_rx,
  output logic                   tx_busy,
  output logic                   frame_err
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(BUF_WORDS);
  localparam int IW  = $clog2(CMD_BYTES + 1);
`ifdef UART_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(NB - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(CMD_BYTES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [IW-1:0]          tx_idx_q, tx_idx_d;
  logic [CMD_BYTES*8-1:0] tx_sh_q, tx_sh_d;
  logic [NB-1:0]          tx_frm_q, tx_frm_d, tx_frame;
  logic                   tx_q, tx_d, busy_q, busy_d;

  rx_state_e              rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [NB-1:0]          rx_sh_q, rx_sh_d;
  logic                   rx_s1_q, rx_s2_q, rx_p_q;
  logic                   rx_valid_q, rx_valid_d, fe_q, fe_d, rx_ok;
  logic [7:0]             rx_byte_q, rx_byte_d;

  logic [AW-1:0]          wp_q, wp_d;
  logic                   phase_hi_q, phase_hi_d;
  logic [7:0]             held_q, held_d;
  logic [15:0]            bytes_q, bytes_d, word_q, wdata;
  logic                   we;
  logic [15:0]            mem [BUF_WORDS];
  logic                   unused_addr;

`ifdef UART_PARITY_EN
  assign tx_frame = {^tx_sh_q[7:0], tx_sh_q[7:0]};
  assign rx_ok    = rx_s2_q && !(^rx_sh_q);
`else
  assign tx_frame = tx_sh_q[7:0];
  assign rx_ok    = rx_s2_q;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == BIT_END) ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_frm_d   = tx_frm_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (uart_start) begin
          tx_sh_d    = cmd_buf;
          tx_idx_d   = '0;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BIT_END) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_d       = tx_frame[0];
        tx_frm_d   = tx_frame >> 1;
      end
      TX_DATA: if (tx_cnt_q == BIT_END) begin
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_d     = tx_frm_q[0];
          tx_frm_d = tx_frm_q >> 1;
        end
      end
      default: if (tx_cnt_q == BIT_END) begin
        if (tx_idx_q == LAST_IDX) begin
          tx_state_d = TX_IDLE;
          busy_d     = 1'b0;
        end else begin
          tx_idx_d   = tx_idx_q + 1'b1;
          tx_sh_d    = tx_sh_q >> 8;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
    endcase
  end

  // Receiver samples near mid-bit: half a bit after the detected edge, then every DIV clocks.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = (rx_cnt_q == BIT_END) ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    fe_d       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q && rx_p_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[NB-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end
      default: if (rx_cnt_q == BIT_END) begin
        rx_state_d = RX_IDLE;
        rx_valid_d = rx_ok;
        fe_d       = !rx_ok;
        rx_byte_d  = rx_sh_q[7:0];
      end
    endcase
  end

  // A clear in the same cycle as an accepted byte drops that byte.
  always_comb begin
    wp_d       = wp_q;
    phase_hi_d = phase_hi_q;
    held_d     = held_q;
    bytes_d    = bytes_q;
    we         = 1'b0;
    wdata      = {held_q, rx_byte_q};
    if (reset_bytes_transmitted) begin
      wp_d       = AW'(1);
      phase_hi_d = 1'b1;
      bytes_d    = '0;
    end else if (rx_valid_q) begin
      we      = 1'b1;
      bytes_d = (bytes_q == 16'hFFFF) ? bytes_q : bytes_q + 16'd1;
      if (phase_hi_q) begin
        wdata      = {rx_byte_q, 8'h00};
        held_d     = rx_byte_q;
        phase_hi_d = 1'b0;
      end else begin
        wp_d       = (wp_q == AW'(BUF_WORDS - 1)) ? '0 : wp_q + 1'b1;
        phase_hi_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_frm_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_p_q     <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      fe_q       <= 1'b0;
      wp_q       <= AW'(1);
      phase_hi_q <= 1'b1;
      held_q     <= '0;
      bytes_q    <= '0;
      word_q     <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_frm_q   <= tx_frm_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_p_q     <= rx_s2_q;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      fe_q       <= fe_d;
      wp_q       <= wp_d;
      phase_hi_q <= phase_hi_d;
      held_q     <= held_d;
      bytes_q    <= bytes_d;
      if (buffer_read) word_q <= mem[read_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wp_q] <= wdata;
  end

  assign unused_addr = ^read_addr[15:AW];
  assign word_in     = word_q;
  assign bytes_in    = bytes_q;
  assign uart_tx     = tx_q;
  assign tx_busy     = busy_q;
  assign frame_err   = fe_q;
endmodule
